wrp_shff_seq_ctrl: RTL and testbench
====================================

# wrp_shff_seq_ctrl

Ping-pong transpose sequencer for the shuffle buffer. Accepts data blocks row-major from the upstream shuffle network and releases them column-major to the AIE side. It generates the write and read addresses, enables and per-block done pulses for the two-bank shuffle memory. Its `buf_wdone`/`buf_rdone` outputs drive the shuffle FIFO token controller directly.

## Interface
Parameters:
- `ROW_W`, default 5: log2 of rows per bank (32 rows).
- `COL_W`, default 5: log2 of columns per bank (32 columns).
- `ADDR_W`, derived, 1+ROW_W+COL_W (11): block address width; MSB selects the bank.

Ports:
- `clk`  in  1  sole clock.
- `srst`  in  1  synchronous reset, active-high.
- `wr_valid`  in  1  upstream has a block to write.
- `wr_ready`  out  1  write can be accepted this cycle.
- `rd_ready`  in  1  downstream takes a block this cycle.
- `rd_valid`  out  1  a block is available to read.
- `mem_wen`  out  1  memory write enable.
- `mem_waddr`  out  ADDR_W  memory write address {bank,row,col}.
- `mem_ren`  out  1  memory read enable.
- `mem_raddr`  out  ADDR_W  memory read address {bank,row,col}.
- `rd_last`  out  1  qualifies `mem_ren`; high on the last read of a bank.
- `buf_wdone`  out  1  one pulse per written block.
- `buf_rdone`  out  1  one pulse per read block.
- `bank_rdy`  out  2  bit b is high when bank b is READY or DRAIN.

## Operation
- Each bank holds N = 2^(ROW_W+COL_W) blocks. Each bank has one of four states: FREE(0), FILL(1), READY(2), DRAIN(3).
- Write pointer: `wbank` plus row/col counters. Writes go row-major: col increments fastest, and row increments on col wrap.
- Read pointer: `rbank` plus row/col counters. Reads go column-major: row increments fastest, and col increments on row wrap. This produces the transpose.
- `wr_ready` = state[wbank] ∈ {FREE, FILL}. `rd_valid` = state[rbank] ∈ {READY, DRAIN}. Both are decoded from registered state only, never from `wr_valid`/`rd_ready`.
- A write fires on `wr_valid & wr_ready`:
  - first write into a FREE bank: FREE→FILL;
  - write N: FILL→READY, counters wrap to 0, `wbank` toggles.
  - N=1 goes FREE→READY directly.
- A read fires on `rd_valid & rd_ready`:
  - first read: READY→DRAIN;
  - read N: DRAIN→FREE, `rd_last` is set, counters wrap, `rbank` toggles.
- Write and read fire independently in the same cycle, so full throughput is 1 write + 1 read per cycle.
- Simultaneous events:
  - The write and read banks can never be the same bank in a conflicting state.
  - If one bank goes FILL→READY and the other goes DRAIN→FREE in the same cycle, both transitions apply.
- Boundary conditions:
  - Both banks READY/DRAIN: `wr_ready`=0.
  - Both banks FREE/FILL: `rd_valid`=0.
  - A bank that becomes FREE is writable on the next cycle.
  - A bank that becomes READY is readable on the next cycle.
- Reset at any point, including mid-fill or mid-drain: both banks FREE, pointers and counters 0, all pending data discarded.

## Timing
- Reset values of all outputs: `wr_ready`=1, `rd_valid`=0, `mem_wen`=0, `mem_ren`=0, `mem_waddr`=0, `mem_raddr`=0, `rd_last`=0, `buf_wdone`=0, `buf_rdone`=0, `bank_rdy`=0.
- `wr_ready`=1 on the first cycle after `srst` deasserts.
- `mem_wen`/`mem_waddr` are registered and appear 1 cycle after the write handshake. `buf_wdone` asserts in the same cycle as `mem_wen`.
- `mem_ren`/`mem_raddr`/`rd_last` are registered and appear 1 cycle after the read handshake. `buf_rdone` asserts in the same cycle as `mem_ren`.
- State update is visible on `wr_ready`/`rd_valid`/`bank_rdy` 1 cycle after the handshake.
- Minimum latency from the last write of a bank to the first `rd_valid` is 1 cycle.
- Counters use modular arithmetic at ROW_W/COL_W width; there are no saturating paths.

## Structure
- Package `shff_pkg`:
  - bank-state constants FREE/FILL/READY/DRAIN (2-bit);
  - default ROW_W/COL_W;
  - ADDR_W derivation.
- Sub-module `wrp_shff_bank_fsm`, instantiated twice, one per bank:
  - inputs: wr_fire, wr_end, rd_fire, rd_end, srst;
  - outputs: 2-bit state.
- Top level holds both pointer/counter pairs, handshake decode, and output registers.

## Test plan
- Fill at defaults with `wr_valid`=1 and `rd_ready`=0:
  - `mem_waddr` runs 0..1023, then 1024..2047;
  - `wr_ready` falls after write 2048;
  - `bank_rdy`=2'b11;
  - 2048 `buf_wdone` pulses.
- Drain bank 0 with `rd_ready`=1:
  - `mem_raddr` sequence is 0,32,64,…,992,1,33,…,1023;
  - `rd_last` is set only with 1023;
  - bank 0 is FREE and `wr_ready`=1 one cycle after the 1024th read.
- Streaming with `wr_valid`=`rd_ready`=1 for 4096+ cycles:
  - a write and a read fire every cycle once the first bank is READY;
  - the `buf_wdone` count equals the `buf_rdone` count + 1024 in steady state.
- Same-cycle boundary: the last write of bank 1 coincides with the last read of bank 0:
  - next cycle, bank 1 is READY, bank 0 is FREE, `wbank`=0, `rbank`=1.
- Reset mid-fill and mid-drain:
  - assert `srst` at write 500 of bank 1 while bank 0 is draining at read 200;
  - next cycle, all outputs hold their reset values;
  - the next write address is 0.
- Small parameters ROW_W=1, COL_W=2, with random `wr_valid`/`rd_ready`:
  - the scoreboard checks the transposed order 0,4,1,5,2,6,3,7 per bank;
  - no write into a READY/DRAIN bank and no read from a FREE/FILL bank.

Source files
------------

// File: rtl/shff_pkg.sv
// Shared types and sizing for the shuffle-buffer transpose sequencer.
package shff_pkg;

    localparam int unsigned DEF_ROW_W = 5;
    localparam int unsigned DEF_COL_W = 5;

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_READY = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_e;

    // Block address is {bank, row, col}.
    function automatic int unsigned addr_w(input int unsigned row_w, input int unsigned col_w);
        return 1 + row_w + col_w;
    endfunction

endpackage

// File: rtl/wrp_shff_bank_fsm.sv
// Per-bank occupancy FSM: FREE -> FILL -> READY -> DRAIN -> FREE.
module wrp_shff_bank_fsm
    import shff_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        wr_fire,
    input  logic        wr_end,
    input  logic        rd_fire,
    input  logic        rd_end,
    output bank_state_e state
);

    bank_state_e state_q;
    bank_state_e state_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= BANK_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // A single-block bank (wr_end on the first write) skips FILL/DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BANK_FREE:  if (wr_fire) state_d = wr_end ? BANK_READY : BANK_FILL;
            BANK_FILL:  if (wr_fire && wr_end) state_d = BANK_READY;
            BANK_READY: if (rd_fire) state_d = rd_end ? BANK_FREE : BANK_DRAIN;
            BANK_DRAIN: if (rd_fire && rd_end) state_d = BANK_FREE;
            default:    state_d = BANK_FREE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/wrp_shff_seq_ctrl.sv
// Ping-pong transpose sequencer: row-major writes, column-major reads over two banks.
module wrp_shff_seq_ctrl
    import shff_pkg::*;
#(
    parameter  int unsigned ROW_W  = DEF_ROW_W,
    parameter  int unsigned COL_W  = DEF_COL_W,
    localparam int unsigned ADDR_W = addr_w(ROW_W, COL_W)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              rd_last,
    output logic              buf_wdone,
    output logic              buf_rdone,
    output logic [1:0]        bank_rdy
);

    logic             wbank_q, wbank_d;
    logic [ROW_W-1:0] wrow_q, wrow_d;
    logic [COL_W-1:0] wcol_q, wcol_d;
    logic             rbank_q, rbank_d;
    logic [ROW_W-1:0] rrow_q, rrow_d;
    logic [COL_W-1:0] rcol_q, rcol_d;

    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic              mem_ren_q, mem_ren_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic              rd_last_q, rd_last_d;

    bank_state_e st0, st1;
    bank_state_e wr_st, rd_st;
    logic        wr_fire, wr_end, rd_fire, rd_end;

    // Handshake decode uses registered bank state only.
    assign wr_st    = wbank_q ? st1 : st0;
    assign rd_st    = rbank_q ? st1 : st0;
    assign wr_ready = (wr_st == BANK_FREE) || (wr_st == BANK_FILL);
    assign rd_valid = (rd_st == BANK_READY) || (rd_st == BANK_DRAIN);
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_ready & rd_valid;
    assign wr_end   = (&wrow_q) & (&wcol_q);
    assign rd_end   = (&rrow_q) & (&rcol_q);

    wrp_shff_bank_fsm u_bank0 (
        .clk     (clk),
        .srst    (srst),
        .wr_fire (wr_fire & ~wbank_q),
        .wr_end  (wr_end),
        .rd_fire (rd_fire & ~rbank_q),
        .rd_end  (rd_end),
        .state   (st0)
    );

    wrp_shff_bank_fsm u_bank1 (
        .clk     (clk),
        .srst    (srst),
        .wr_fire (wr_fire & wbank_q),
        .wr_end  (wr_end),
        .rd_fire (rd_fire & rbank_q),
        .rd_end  (rd_end),
        .state   (st1)
    );

    // Write walks col fastest, read walks row fastest: that is the transpose.
    always_comb begin
        wbank_d = wbank_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        rbank_d = rbank_q;
        rrow_d  = rrow_q;
        rcol_d  = rcol_q;
        if (wr_fire) begin
            wcol_d = wcol_q + COL_W'(1);
            if (&wcol_q) wrow_d = wrow_q + ROW_W'(1);
            if (wr_end)  wbank_d = ~wbank_q;
        end
        if (rd_fire) begin
            rrow_d = rrow_q + ROW_W'(1);
            if (&rrow_q) rcol_d = rcol_q + COL_W'(1);
            if (rd_end)  rbank_d = ~rbank_q;
        end
    end

    always_comb begin
        mem_wen_d   = wr_fire;
        mem_waddr_d = wr_fire ? {wbank_q, wrow_q, wcol_q} : mem_waddr_q;
        mem_ren_d   = rd_fire;
        mem_raddr_d = rd_fire ? {rbank_q, rrow_q, rcol_q} : mem_raddr_q;
        rd_last_d   = rd_fire & rd_end;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wbank_q     <= 1'b0;
            wrow_q      <= '0;
            wcol_q      <= '0;
            rbank_q     <= 1'b0;
            rrow_q      <= '0;
            rcol_q      <= '0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            wbank_q     <= wbank_d;
            wrow_q      <= wrow_d;
            wcol_q      <= wcol_d;
            rbank_q     <= rbank_d;
            rrow_q      <= rrow_d;
            rcol_q      <= rcol_d;
            mem_wen_q   <= mem_wen_d;
            mem_waddr_q <= mem_waddr_d;
            mem_ren_q   <= mem_ren_d;
            mem_raddr_q <= mem_raddr_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign mem_wen   = mem_wen_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_ren   = mem_ren_q;
    assign mem_raddr = mem_raddr_q;
    assign rd_last   = rd_last_q;
    assign buf_wdone = mem_wen_q;
    assign buf_rdone = mem_ren_q;
    assign bank_rdy  = {(st1 == BANK_READY) || (st1 == BANK_DRAIN),
                        (st0 == BANK_READY) || (st0 == BANK_DRAIN)};

endmodule

// File: tb/tb_wrp_shff_seq_ctrl.sv
// Bench for wrp_shff_seq_ctrl: default-size and small-size instances against a block-count model.
module tb_wrp_shff_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst_a[2];
    logic       wv_a[2];
    logic       rr_a[2];
    logic       wr_ready_a[2];
    logic       rd_valid_a[2];
    logic       mem_wen_a[2];
    logic       mem_ren_a[2];
    logic       rd_last_a[2];
    logic       wdone_a[2];
    logic       rdone_a[2];
    logic [1:0] bank_rdy_a[2];
    logic [10:0] b_waddr, b_raddr;
    logic [3:0]  s_waddr, s_raddr;

    wrp_shff_seq_ctrl u_big (
        .clk(clk), .srst(srst_a[0]), .wr_valid(wv_a[0]), .wr_ready(wr_ready_a[0]),
        .rd_ready(rr_a[0]), .rd_valid(rd_valid_a[0]), .mem_wen(mem_wen_a[0]),
        .mem_waddr(b_waddr), .mem_ren(mem_ren_a[0]), .mem_raddr(b_raddr),
        .rd_last(rd_last_a[0]), .buf_wdone(wdone_a[0]), .buf_rdone(rdone_a[0]),
        .bank_rdy(bank_rdy_a[0])
    );

    wrp_shff_seq_ctrl #(.ROW_W(1), .COL_W(2)) u_small (
        .clk(clk), .srst(srst_a[1]), .wr_valid(wv_a[1]), .wr_ready(wr_ready_a[1]),
        .rd_ready(rr_a[1]), .rd_valid(rd_valid_a[1]), .mem_wen(mem_wen_a[1]),
        .mem_waddr(s_waddr), .mem_ren(mem_ren_a[1]), .mem_raddr(s_raddr),
        .rd_last(rd_last_a[1]), .buf_wdone(wdone_a[1]), .buf_rdone(rdone_a[1]),
        .bank_rdy(bank_rdy_a[1])
    );

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;
    int rcnt  = 0;

    // Model: only the running write/read block counts per instance.
    int m_w[2];
    int m_r[2];
    int nn[2]   = '{1024, 8};
    int rows[2] = '{32, 2};
    int cols[2] = '{32, 4};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_wr_ready(input int i);
        return (m_w[i] / nn[i] - m_r[i] / nn[i]) < 2;
    endfunction

    function automatic bit m_rd_valid(input int i);
        return m_r[i] < (m_w[i] / nn[i]) * nn[i];
    endfunction

    function automatic logic [1:0] m_bank_rdy(input int i);
        logic [1:0] v;
        v = 2'b00;
        for (int k = m_r[i] / nn[i]; k < m_w[i] / nn[i]; k++) v[k % 2] = 1'b1;
        return v;
    endfunction

    function automatic int m_waddr(input int i);
        return ((m_w[i] / nn[i]) % 2) * nn[i] + m_w[i] % nn[i];
    endfunction

    function automatic int m_raddr(input int i);
        int p;
        p = m_r[i] % nn[i];
        return ((m_r[i] / nn[i]) % 2) * nn[i] + (p % rows[i]) * cols[i] + p / rows[i];
    endfunction

    // One clock of stimulus on instance i; the other instance is held idle.
    task automatic step(input int i, input bit wv, input bit rr);
        bit er, ev, wf, rf, last;
        logic [10:0] wa, ra;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            wv_a[j] = 1'b0;
            rr_a[j] = 1'b0;
        end
        wv_a[i] = wv;
        rr_a[i] = rr;
        er = m_wr_ready(i);
        ev = m_rd_valid(i);
        check_eq("wr_ready", 32'(wr_ready_a[i]), 32'(er));
        check_eq("rd_valid", 32'(rd_valid_a[i]), 32'(ev));
        check_eq("bank_rdy", 32'(bank_rdy_a[i]), 32'(m_bank_rdy(i)));
        wf   = wv & er;
        rf   = rr & ev;
        last = rf && (m_r[i] % nn[i] == nn[i] - 1);
        @(posedge clk);
        #1;
        wa = (i == 0) ? b_waddr : 11'(s_waddr);
        ra = (i == 0) ? b_raddr : 11'(s_raddr);
        check_eq("mem_wen", 32'(mem_wen_a[i]), 32'(wf));
        check_eq("buf_wdone", 32'(wdone_a[i]), 32'(wf));
        check_eq("mem_ren", 32'(mem_ren_a[i]), 32'(rf));
        check_eq("buf_rdone", 32'(rdone_a[i]), 32'(rf));
        check_eq("rd_last", 32'(rd_last_a[i]), 32'(last));
        if (wf) check_eq("mem_waddr", 32'(wa), 32'(m_waddr(i)));
        if (rf) check_eq("mem_raddr", 32'(ra), 32'(m_raddr(i)));
        if (i == 0) begin
            if (wdone_a[0]) wcnt++;
            if (rdone_a[0]) rcnt++;
        end
        if (wf) m_w[i]++;
        if (rf) m_r[i]++;
    endtask

    task automatic do_reset(input int i);
        logic [10:0] wa, ra;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            wv_a[j] = 1'b0;
            rr_a[j] = 1'b0;
        end
        srst_a[i] = 1'b1;
        @(posedge clk);
        #1;
        wa = (i == 0) ? b_waddr : 11'(s_waddr);
        ra = (i == 0) ? b_raddr : 11'(s_raddr);
        check_eq("rst_wr_ready", 32'(wr_ready_a[i]), 32'd1);
        check_eq("rst_rd_valid", 32'(rd_valid_a[i]), 32'd0);
        check_eq("rst_mem_wen", 32'(mem_wen_a[i]), 32'd0);
        check_eq("rst_mem_ren", 32'(mem_ren_a[i]), 32'd0);
        check_eq("rst_mem_waddr", 32'(wa), 32'd0);
        check_eq("rst_mem_raddr", 32'(ra), 32'd0);
        check_eq("rst_rd_last", 32'(rd_last_a[i]), 32'd0);
        check_eq("rst_buf_wdone", 32'(wdone_a[i]), 32'd0);
        check_eq("rst_buf_rdone", 32'(rdone_a[i]), 32'd0);
        check_eq("rst_bank_rdy", 32'(bank_rdy_a[i]), 32'd0);
        @(negedge clk);
        srst_a[i] = 1'b0;
        m_w[i] = 0;
        m_r[i] = 0;
        if (i == 0) begin
            wcnt = 0;
            rcnt = 0;
        end
    endtask

    initial begin
        for (int j = 0; j < 2; j++) begin
            srst_a[j] = 1'b1;
            wv_a[j]   = 1'b0;
            rr_a[j]   = 1'b0;
            m_w[j]    = 0;
            m_r[j]    = 0;
        end
        repeat (2) @(posedge clk);
        do_reset(0);
        do_reset(1);

        // Fill both banks with no reads; the 2049th attempt must be refused.
        repeat (2049) step(0, 1'b1, 1'b0);
        check_eq("fill_wdone_cnt", 32'(wcnt), 32'd2048);
        check_eq("fill_bank_rdy", 32'(bank_rdy_a[0]), 32'h3);
        check_eq("fill_wr_ready", 32'(wr_ready_a[0]), 32'd0);

        // Drain bank 0 in transposed order.
        repeat (1024) step(0, 1'b0, 1'b1);
        check_eq("drain_wr_ready", 32'(wr_ready_a[0]), 32'd1);
        check_eq("drain_bank_rdy", 32'(bank_rdy_a[0]), 32'h2);

        // Full-throughput streaming; 2048 cycles lands on bank1 fill-end with bank0 drain-end.
        repeat (2048) step(0, 1'b1, 1'b1);
        check_eq("bnd_bank_rdy", 32'(bank_rdy_a[0]), 32'h2);
        check_eq("bnd_wr_ready", 32'(wr_ready_a[0]), 32'd1);
        check_eq("bnd_rd_valid", 32'(rd_valid_a[0]), 32'd1);
        repeat (2152) step(0, 1'b1, 1'b1);
        check_eq("stream_diff", 32'(wcnt - rcnt), 32'd1024);

        // Reset with bank 1 mid-fill (write 500) and bank 0 mid-drain (read 200).
        do_reset(0);
        repeat (1024) step(0, 1'b1, 1'b0);
        repeat (200)  step(0, 1'b1, 1'b1);
        repeat (300)  step(0, 1'b1, 1'b0);
        check_eq("mid_bank_rdy", 32'(bank_rdy_a[0]), 32'h1);
        do_reset(0);
        step(0, 1'b1, 1'b0);
        check_eq("post_rst_waddr", 32'(b_waddr), 32'd0);

        // Small geometry: random handshakes, write-heavy then read-heavy, with a reset between.
        for (int k = 0; k < 1200; k++)
            step(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        do_reset(1);
        for (int k = 0; k < 1200; k++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        for (int k = 0; k < 600; k++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
